guess_game_controller: RTL and testbench

Sequencing FSM for the number-guessing game. It latches a secret value, accepts player guesses, and compares each guess against the secret. It also tracks remaining attempts and times the feedback phase. Its outputs (game state, result code, remaining guesses) directly drive the seven-segment feedback display block.

---
 rtl/guess_game_controller_if.sv | 51 +++++
 rtl/guess_game_controller.sv | 230 +++++++++++++++++++++++
 tb/tb_guess_game_controller.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/guess_game_controller_if.sv
// ----------------------------------------------------------------------------
// guess_game_controller_if
//   Groups the player-facing controls and the display-facing results of the
//   number-guessing game controller into one bundle.
//
//   Signals
//     start         level, rising edge starts a new game
//     submit        level, rising edge submits guess_in
//     guess_in[3:0] player guess value
//     fixed_secret  1: secret is taken from secret_in when a game starts
//     secret_in[3:0] directed secret value
//     state[2:0]    000 WAIT, 001 GUESS, 010 FEEDBACK, 011 WIN, 100 LOSE
//     guess[3:0]    result code: 0000 low, 0001 high, 0010 correct, 1111 none
//     remaining_guesses[3:0] attempts left in the current game
//
//   Modports
//     master : the player / stimulus side (drives controls, reads results)
//     slave  : the controller side (reads controls, drives results)
// ----------------------------------------------------------------------------
interface guess_game_controller_if;
  logic       start;
  logic       submit;
  logic [3:0] guess_in;
  logic       fixed_secret;
  logic [3:0] secret_in;
  logic [2:0] state;
  logic [3:0] guess;
  logic [3:0] remaining_guesses;

  modport master (
    output start,
    output submit,
    output guess_in,
    output fixed_secret,
    output secret_in,
    input  state,
    input  guess,
    input  remaining_guesses
  );

  modport slave (
    input  start,
    input  submit,
    input  guess_in,
    input  fixed_secret,
    input  secret_in,
    output state,
    output guess,
    output remaining_guesses
  );
endinterface

// File: rtl/guess_game_controller.sv
// ----------------------------------------------------------------------------
// guess_game_controller
//   Sequencing FSM for the number-guessing game. A secret is latched when a
//   game starts (either a directed value or a free-running seed counter),
//   each submitted guess is compared against it, attempts are counted down,
//   and a short FEEDBACK phase is timed between guesses. The state, result
//   code and remaining-attempt count are registered and feed the
//   seven-segment display block directly.
//
//   Parameters
//     MAX_GUESSES     attempts per game (1..15)
//     FEEDBACK_CYCLES cycles the FEEDBACK state is held (>= 1)
//     SECRET_MAX      largest secret value; the seed counter wraps here (<= 15)
//
//   Ports
//     clk    system clock, rising edge
//     reset  synchronous, active-high reset
//     bus    guess_game_controller_if.slave (controls in, results out)
// ----------------------------------------------------------------------------
module guess_game_controller #(
  parameter int MAX_GUESSES     = 5,
  parameter int FEEDBACK_CYCLES = 4,
  parameter int SECRET_MAX      = 15
) (
  input  logic                          clk,
  input  logic                          reset,
  guess_game_controller_if.slave        bus
);

  localparam int TIMER_W = (FEEDBACK_CYCLES > 1) ? $clog2(FEEDBACK_CYCLES) : 1;

  localparam logic [3:0] CODE_LOW     = 4'b0000;
  localparam logic [3:0] CODE_HIGH    = 4'b0001;
  localparam logic [3:0] CODE_CORRECT = 4'b0010;
  localparam logic [3:0] CODE_NONE    = 4'b1111;

  localparam logic [3:0]         REM_FULL   = 4'(MAX_GUESSES);
  localparam logic [3:0]         SEED_LAST  = 4'(SECRET_MAX);
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(FEEDBACK_CYCLES - 1);

  typedef enum logic [2:0] {
    S_WAIT     = 3'b000,
    S_GUESS    = 3'b001,
    S_FEEDBACK = 3'b010,
    S_WIN      = 3'b011,
    S_LOSE     = 3'b100
  } state_t;

  // Registered state
  state_t             state_r;
  logic [3:0]         guess_r;
  logic [3:0]         remaining_r;
  logic [3:0]         secret_r;
  logic [3:0]         seed_r;
  logic [TIMER_W-1:0] timer_r;
  logic               start_q_r;
  logic               submit_q_r;

  // Next-state values
  state_t             state_nxt_s;
  logic [3:0]         guess_nxt_s;
  logic [3:0]         remaining_nxt_s;
  logic [3:0]         secret_nxt_s;
  logic [TIMER_W-1:0] timer_nxt_s;

  logic               start_p_s;
  logic               submit_p_s;
  logic [3:0]         start_secret_s;

  // A held level yields a single pulse on its first cycle.
  assign start_p_s  = bus.start  & ~start_q_r;
  assign submit_p_s = bus.submit & ~submit_q_r;

  // Secret chosen when a game starts.
  assign start_secret_s = bus.fixed_secret ? bus.secret_in : seed_r;

  // Edge-detect history registers, refreshed every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      start_q_r  <= 1'b0;
      submit_q_r <= 1'b0;
    end else begin
      start_q_r  <= bus.start;
      submit_q_r <= bus.submit;
    end
  end

  // Free-running seed counter; the player's start timing picks the secret.
  always_ff @(posedge clk) begin
    if (reset) begin
      seed_r <= 4'd0;
    end else if (seed_r == SEED_LAST) begin
      seed_r <= 4'd0;
    end else begin
      seed_r <= seed_r + 4'd1;
    end
  end

  // FSM state and datapath register update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= S_WAIT;
      guess_r     <= CODE_NONE;
      remaining_r <= REM_FULL;
      secret_r    <= 4'd0;
      timer_r     <= '0;
    end else begin
      state_r     <= state_nxt_s;
      guess_r     <= guess_nxt_s;
      remaining_r <= remaining_nxt_s;
      secret_r    <= secret_nxt_s;
      timer_r     <= timer_nxt_s;
    end
  end

  // Next-state and datapath decisions; every register holds by default.
  always_comb begin
    state_nxt_s     = state_r;
    guess_nxt_s     = guess_r;
    remaining_nxt_s = remaining_r;
    secret_nxt_s    = secret_r;
    timer_nxt_s     = timer_r;

    case (state_r)
      S_WAIT, S_WIN, S_LOSE: begin
        // Only a new game leaves these states; submits are ignored.
        if (start_p_s) begin
          state_nxt_s     = S_GUESS;
          secret_nxt_s    = start_secret_s;
          remaining_nxt_s = REM_FULL;
          guess_nxt_s     = CODE_NONE;
        end else begin
          state_nxt_s = state_r;
        end
      end

      S_GUESS: begin
        // start has priority: a simultaneous submit is discarded.
        if (start_p_s) begin
          state_nxt_s     = S_GUESS;
          secret_nxt_s    = start_secret_s;
          remaining_nxt_s = REM_FULL;
          guess_nxt_s     = CODE_NONE;
        end else if (submit_p_s) begin
          if (bus.guess_in == secret_r) begin
            state_nxt_s = S_WIN;
            guess_nxt_s = CODE_CORRECT;
          end else begin
            // In GUESS remaining_r is always >= 1, so this cannot underflow.
            state_nxt_s     = S_FEEDBACK;
            guess_nxt_s     = (bus.guess_in < secret_r) ? CODE_LOW : CODE_HIGH;
            remaining_nxt_s = remaining_r - 4'd1;
            timer_nxt_s     = TIMER_LOAD;
          end
        end else begin
          state_nxt_s = S_GUESS;
        end
      end

      S_FEEDBACK: begin
        // Timer loaded with N-1 and left on zero gives exactly N cycles here.
        if (timer_r == '0) begin
          if (remaining_r == 4'd0) begin
            state_nxt_s = S_LOSE;
          end else begin
            state_nxt_s = S_GUESS;
            guess_nxt_s = CODE_NONE;
          end
        end else begin
          timer_nxt_s = timer_r - TIMER_W'(1);
        end
      end

      default: begin
        // Corrupted encoding: recover to a clean idle game.
        state_nxt_s     = S_WAIT;
        guess_nxt_s     = CODE_NONE;
        remaining_nxt_s = REM_FULL;
        secret_nxt_s    = 4'd0;
        timer_nxt_s     = '0;
      end
    endcase
  end

  assign bus.state             = state_r;
  assign bus.guess             = guess_r;
  assign bus.remaining_guesses = remaining_r;

  guess_game_checker #(
    .MAX_GUESSES (MAX_GUESSES)
  ) u_checker (
    .clk               (clk),
    .reset             (reset),
    .state             (state_r),
    .remaining_guesses (remaining_r)
  );

endmodule

// ----------------------------------------------------------------------------
// guess_game_checker
//   Invariants of the controller outputs.
//
//   Ports
//     clk, reset         as the controller
//     state[2:0]         controller state register
//     remaining_guesses  controller attempt counter
// ----------------------------------------------------------------------------
module guess_game_checker #(
  parameter int MAX_GUESSES = 5
) (
  input logic       clk,
  input logic       reset,
  input logic [2:0] state,
  input logic [3:0] remaining_guesses
);

  // The attempt counter never exceeds the per-game allowance.
  remaining_in_range: assert property (
    @(posedge clk) disable iff (reset)
      remaining_guesses <= 4'(MAX_GUESSES)
  );

  // Only the five defined encodings are ever visible after reset.
  state_legal: assert property (
    @(posedge clk) disable iff (reset)
      state <= 3'b100
  );

endmodule

// File: tb/tb_guess_game_controller.sv
// ----------------------------------------------------------------------------
// tb_guess_game_controller
//   Directed bench for guess_game_controller. Stimulus pushes the expected
//   sequence of distinct output triples (state, guess, remaining) into a
//   queue; a monitor pops an entry whenever the outputs change and also
//   checks how long each FEEDBACK phase lasted.
// ----------------------------------------------------------------------------
module tb_guess_game_controller;

  localparam logic [2:0] ST_WAIT = 3'b000;
  localparam logic [2:0] ST_GUESS = 3'b001;
  localparam logic [2:0] ST_FB   = 3'b010;
  localparam logic [2:0] ST_WIN  = 3'b011;
  localparam logic [2:0] ST_LOSE = 3'b100;

  localparam logic [3:0] C_LOW  = 4'b0000;
  localparam logic [3:0] C_HIGH = 4'b0001;
  localparam logic [3:0] C_OK   = 4'b0010;
  localparam logic [3:0] C_NONE = 4'b1111;

  logic clk = 1'b0;
  logic reset;

  guess_game_controller_if gif ();

  guess_game_controller #(
    .MAX_GUESSES     (5),
    .FEEDBACK_CYCLES (4),
    .SECRET_MAX      (15)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (gif.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] st;
    logic [3:0] g;
    logic [3:0] rem;
    int         hold;
    int         id;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   next_id      = 0;

  task automatic expect_out(input logic [2:0] st, input logic [3:0] g,
                            input logic [3:0] rem, input int hold);
    exp_t e;
    e.st   = st;
    e.g    = g;
    e.rem  = rem;
    e.hold = hold;
    e.id   = next_id;
    next_id++;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    gif.start = 1'b1;
    cyc(1);
    gif.start = 1'b0;
  endtask

  task automatic submit_val(input logic [3:0] v);
    gif.guess_in = v;
    gif.submit   = 1'b1;
    cyc(1);
    gif.submit   = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: %0d expected outputs never appeared, required 0", exp_q.size());
      exp_q.delete();
    end
    cyc(3);
  endtask

  // Monitor: one comparison per output change, plus FEEDBACK duration.
  logic [10:0] prev_out;
  logic [10:0] cur_out;
  bit          have_prev = 1'b0;
  int          held      = 0;
  int          prev_hold = 0;
  int          prev_id   = 0;
  exp_t        mon_e;

  always begin
    @(posedge clk);
    #1;
    cur_out = {gif.state, gif.guess, gif.remaining_guesses};
    if (!have_prev || cur_out !== prev_out) begin
      if (have_prev && prev_hold != 0) begin
        tests_run++;
        if (held != prev_hold) begin
          tests_failed++;
          $display("FAIL hold[%0d]: held %0d cycles, required %0d", prev_id, held, prev_hold);
        end
      end
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected: output st=%b g=%b rem=%0d, required no change",
                 gif.state, gif.guess, gif.remaining_guesses);
        prev_hold = 0;
        prev_id   = -1;
      end else begin
        mon_e = exp_q.pop_front();
        if (cur_out !== {mon_e.st, mon_e.g, mon_e.rem}) begin
          tests_failed++;
          $display("FAIL out[%0d]: got st=%b g=%b rem=%0d, required st=%b g=%b rem=%0d",
                   mon_e.id, gif.state, gif.guess, gif.remaining_guesses,
                   mon_e.st, mon_e.g, mon_e.rem);
        end
        prev_hold = mon_e.hold;
        prev_id   = mon_e.id;
      end
      prev_out  = cur_out;
      have_prev = 1'b1;
      held      = 1;
    end else begin
      held++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset            = 1'b1;
    gif.start        = 1'b0;
    gif.submit       = 1'b0;
    gif.guess_in     = 4'd0;
    gif.fixed_secret = 1'b0;
    gif.secret_in    = 4'd0;

    // 1: reset state, then a held start gives exactly one transition
    expect_out(ST_WAIT, C_NONE, 4'd5, 0);
    cyc(2);
    reset = 1'b0;
    gif.fixed_secret = 1'b1;
    gif.secret_in    = 4'd7;
    expect_out(ST_GUESS, C_NONE, 4'd5, 0);
    gif.start = 1'b1;
    cyc(3);
    gif.start = 1'b0;
    drain(10);

    // 2: too low, four FEEDBACK cycles, back to GUESS
    expect_out(ST_FB, C_LOW, 4'd4, 4);
    expect_out(ST_GUESS, C_NONE, 4'd4, 0);
    submit_val(4'd3);
    drain(20);

    // 3: new game, too high, then correct; later submits ignored
    expect_out(ST_GUESS, C_NONE, 4'd5, 0);
    pulse_start();
    drain(10);
    expect_out(ST_FB, C_HIGH, 4'd4, 4);
    expect_out(ST_GUESS, C_NONE, 4'd4, 0);
    submit_val(4'd9);
    drain(20);
    expect_out(ST_WIN, C_OK, 4'd4, 0);
    submit_val(4'd7);
    drain(10);
    submit_val(4'd7);
    cyc(2);
    submit_val(4'd3);
    cyc(4);

    // 4: five misses lead to LOSE; start during FEEDBACK ignored
    expect_out(ST_GUESS, C_NONE, 4'd5, 0);
    pulse_start();
    drain(10);
    for (int k = 0; k < 4; k++) begin
      expect_out(ST_FB, C_LOW, 4'(4 - k), 4);
      expect_out(ST_GUESS, C_NONE, 4'(4 - k), 0);
      submit_val(4'(k));
      if (k == 2) pulse_start();
      drain(20);
    end
    expect_out(ST_FB, C_LOW, 4'd0, 4);
    expect_out(ST_LOSE, C_LOW, 4'd0, 0);
    submit_val(4'd4);
    drain(20);
    submit_val(4'd7);
    cyc(4);
    expect_out(ST_GUESS, C_NONE, 4'd5, 0);
    pulse_start();
    drain(10);

    // 5: seed-derived secret, start on the 10th cycle after reset release
    gif.fixed_secret = 1'b0;
    expect_out(ST_WAIT, C_NONE, 4'd5, 0);
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(9);
    expect_out(ST_GUESS, C_NONE, 4'd5, 0);
    pulse_start();
    drain(10);
    expect_out(ST_FB, C_LOW, 4'd4, 4);
    expect_out(ST_GUESS, C_NONE, 4'd4, 0);
    submit_val(4'd8);
    drain(20);
    expect_out(ST_WIN, C_OK, 4'd4, 0);
    submit_val(4'd9);
    drain(10);

    // 6a: reset in the middle of FEEDBACK
    gif.fixed_secret = 1'b1;
    gif.secret_in    = 4'd7;
    expect_out(ST_GUESS, C_NONE, 4'd5, 0);
    pulse_start();
    drain(10);
    expect_out(ST_FB, C_LOW, 4'd4, 0);
    expect_out(ST_WAIT, C_NONE, 4'd5, 0);
    submit_val(4'd2);
    cyc(1);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    drain(10);

    // 6b: start and submit together in GUESS; start wins with new secret 3
    expect_out(ST_GUESS, C_NONE, 4'd5, 0);
    pulse_start();
    drain(10);
    gif.secret_in = 4'd3;
    gif.guess_in  = 4'd5;
    gif.start     = 1'b1;
    gif.submit    = 1'b1;
    cyc(1);
    gif.start     = 1'b0;
    gif.submit    = 1'b0;
    cyc(4);
    expect_out(ST_FB, C_HIGH, 4'd4, 4);
    expect_out(ST_GUESS, C_NONE, 4'd4, 0);
    submit_val(4'd5);
    drain(20);
    expect_out(ST_WIN, C_OK, 4'd4, 0);
    submit_val(4'd3);
    drain(10);

    cyc(5);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
